// File: rtl/pdu_pkg.sv
// pdu_pkg: shared constants and channel map for the PDU input conditioner.
package pdu_pkg;
  localparam int DB_DEFAULT = 1000000;
  localparam int NUM_CH = 8;
  localparam int IN_W = 5;
  localparam int IN_LSB = 3;
  typedef enum int {CH_RUN = 0, CH_STEP = 1, CH_VALID = 2} ch_e;
endpackage

// File: rtl/pdu_input_cond_if.sv
// pdu_input_cond_if: raw panel inputs and their debounced levels/pulses.
interface pdu_input_cond_if;
  logic run_raw;
  logic step_raw;
  logic valid_raw;
  logic [pdu_pkg::IN_W-1:0] in_raw;
  logic run;
  logic step_p;
  logic valid_p;
  logic [pdu_pkg::IN_W-1:0] in_lvl;
  logic [pdu_pkg::IN_W-1:0] in_p;
  modport master (
    output run_raw, step_raw, valid_raw, in_raw,
    input  run, step_p, valid_p, in_lvl, in_p
  );
  modport slave (
    input  run_raw, step_raw, valid_raw, in_raw,
    output run, step_p, valid_p, in_lvl, in_p
  );
endinterface

// File: rtl/pdu_debounce.sv
// pdu_debounce: one channel -- 2-flop sync, hold counter, stable level and rise pulse.
module pdu_debounce import pdu_pkg::*; #(
  parameter int DB_CYCLES = DB_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_lvl,
  output logic o_pulse
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);
  logic r_s1, r_s2, r_st, r_st_d;
  logic [CW-1:0] r_cnt;
  logic w_diff, w_done;
  assign w_diff = r_s2 != r_st;
  assign w_done = r_cnt == CMAX;
  // the counter only runs while the synced input disagrees with the stable level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_st   <= 1'b0;
      r_st_d <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      r_st_d <= r_st;
      r_st   <= (w_diff && w_done) ? r_s2 : r_st;
      r_cnt  <= (w_diff && !w_done) ? r_cnt + 1'b1 : '0;
    end
  end
  assign o_lvl   = r_st;
  assign o_pulse = r_st & ~r_st_d;
endmodule

// File: rtl/pdu_input_cond.sv
// pdu_input_cond: debounces the run/step/valid/data panel inputs, eight independent channels.
module pdu_input_cond import pdu_pkg::*; #(
  parameter int DB_CYCLES = DB_DEFAULT
) (
  input logic clk,
  input logic rst,
  pdu_input_cond_if.slave bus
);
  logic [NUM_CH-1:0] w_raw, w_lvl, w_pulse;
  logic w_unused;
  assign w_raw = {bus.in_raw, bus.valid_raw, bus.step_raw, bus.run_raw};
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pdu_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk     (clk),
      .rst     (rst),
      .i_raw   (w_raw[c]),
      .o_lvl   (w_lvl[c]),
      .o_pulse (w_pulse[c])
    );
  end
  assign bus.run     = w_lvl[CH_RUN];
  assign bus.step_p  = w_pulse[CH_STEP];
  assign bus.valid_p = w_pulse[CH_VALID];
  assign bus.in_lvl  = w_lvl[NUM_CH-1:IN_LSB];
  assign bus.in_p    = w_pulse[NUM_CH-1:IN_LSB];
  // button levels and the run pulse have no consumer
  assign w_unused = ^{w_lvl[CH_STEP], w_lvl[CH_VALID], w_pulse[CH_RUN]};
endmodule
